cosine_job_scheduler: RTL and testbench

// Avalon-MM slave that queues IEEE-754 single-precision theta words from the Nios II.

---
 rtl/cosine_sched_pkg.sv | 20 ++
 rtl/cosine_job_scheduler_sync_fifo.sv | 66 ++++++
 rtl/cosine_job_scheduler.sv | 159 +++++++++++++++
 tb/tb_cosine_job_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cosine_sched_pkg.sv
// Shared types and constants for the cosine job scheduler.
package cosine_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int OVF_BIT = 17;
  localparam int UDF_BIT = 18;
  localparam int TMO_BIT = 19;

  // Quiet NaN returned in place of a result when the engine never answers.
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/cosine_job_scheduler_sync_fifo.sv
// Synchronous FIFO with a combinational head word. A push into a full FIFO
// is accepted only when a pop happens in the same cycle; a pop of an empty
// FIFO is ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rptr_q];

  // Qualify the requests and advance pointers/count; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    do_push = push && (!full || pop);
    do_pop  = pop && !empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/cosine_job_scheduler.sv
// Avalon-MM front end that queues theta words, runs them one at a time
// through the cosine engine and buffers the results for readback.
module cosine_job_scheduler
  import cosine_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        eng_start,
  output logic        eng_clk_en,
  output logic [31:0] eng_theta,
  input  logic        eng_done,
  input  logic [31:0] eng_result,
  output logic        irq
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);

  state_t        state_q, state_d;
  logic [31:0]   theta_q, theta_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          tmo_q, tmo_d;
  logic [31:0]   readdata_q, readdata_d;

  logic          wr_data, wr_stat, rd_data, rd_stat;
  logic          in_push, in_pop, in_full, in_empty;
  logic          out_push, out_pop, out_full, out_empty;
  logic [31:0]   in_dout, out_din, out_dout;
  logic [CW-1:0] in_count, out_count;
  logic          tmo_set, ovf_set, udf_set;
  logic [31:0]   status;
  logic          unused_wdata;

  assign wr_data = avs_write && (avs_address == ADDR_DATA);
  assign wr_stat = avs_write && (avs_address == ADDR_STATUS);
  assign rd_data = avs_read  && (avs_address == ADDR_DATA);
  assign rd_stat = avs_read  && (avs_address == ADDR_STATUS);

  assign unused_wdata = ^{avs_writedata[31:TMO_BIT+1], avs_writedata[OVF_BIT-1:0]};

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_push),
    .pop   (in_pop),
    .din   (avs_writedata),
    .dout  (in_dout),
    .count (in_count),
    .full  (in_full),
    .empty (in_empty)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_push),
    .pop   (out_pop),
    .din   (out_din),
    .dout  (out_dout),
    .count (out_count),
    .full  (out_full),
    .empty (out_empty)
  );

  // Job FSM: a job starts only when a result slot is free, so the output push can never overflow.
  always_comb begin
    state_d  = state_q;
    theta_d  = theta_q;
    timer_d  = timer_q;
    in_pop   = 1'b0;
    out_push = 1'b0;
    out_din  = eng_result;
    tmo_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!in_empty && !out_full) begin
          in_pop  = 1'b1;
          theta_d = in_dout;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          out_push = 1'b1;
          out_din  = eng_result;
          state_d  = IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          out_push = 1'b1;
          out_din  = QNAN;
          tmo_set  = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus decode, sticky flags and read mux; a new error event wins over a same-cycle W1C.
  always_comb begin
    in_push = wr_data && (!in_full || in_pop);
    ovf_set = wr_data && in_full && !in_pop;
    out_pop = rd_data && !out_empty;
    udf_set = rd_data && out_empty;
    ovf_d   = (ovf_q && !(wr_stat && avs_writedata[OVF_BIT])) || ovf_set;
    udf_d   = (udf_q && !(wr_stat && avs_writedata[UDF_BIT])) || udf_set;
    tmo_d   = (tmo_q && !(wr_stat && avs_writedata[TMO_BIT])) || tmo_set;
    status  = {12'b0, tmo_q, udf_q, ovf_q, (state_q != IDLE), 8'(out_count), 8'(in_count)};
    readdata_d = 32'h0;
    if (rd_data) begin
      readdata_d = out_empty ? 32'h0 : out_dout;
    end else if (rd_stat) begin
      readdata_d = status;
    end
  end

  // Control, theta and readdata registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      theta_q    <= '0;
      timer_q    <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      theta_q    <= theta_d;
      timer_q    <= timer_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      tmo_q      <= tmo_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign eng_start    = (state_q == ISSUE);
  assign eng_clk_en   = (state_q != IDLE);
  assign eng_theta    = theta_q;
  assign irq          = !out_empty || ovf_q || udf_q || tmo_q;

endmodule

// File: tb/tb_cosine_job_scheduler.sv
// Bench for cosine_job_scheduler: two instances (long and short timeout)
// share one bus driver; sel picks which one is driven and observed.
`timescale 1ns/1ps
module tb_cosine_job_scheduler;
  import cosine_sched_pkg::*;

  localparam int DEPTH     = 4;
  localparam int TMO_LONG  = 1000;
  localparam int TMO_SHORT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        bus_addr = 1'b0;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [31:0] bus_wdata = 32'h0;
  int          eng_lat = 0;
  logic        force_done = 1'b0;

  logic [31:0] rd_w  [2];
  logic        st_w  [2];
  logic        ce_w  [2];
  logic        irq_w [2];

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] theta;
    logic        done_r = 1'b0;
    logic [31:0] res_r  = 32'h0;
    logic        act    = 1'b0;
    int          cnt    = 0;
    logic        is_sel;
    assign is_sel = (sel == 1'(g));

    cosine_job_scheduler #(.DEPTH(DEPTH), .TIMEOUT(g == 0 ? TMO_LONG : TMO_SHORT)) u_dut (
      .clk           (clk),
      .reset         (rst),
      .avs_address   (bus_addr),
      .avs_write     (bus_write && is_sel),
      .avs_writedata (bus_wdata),
      .avs_read      (bus_read && is_sel),
      .avs_readdata  (rd_w[g]),
      .eng_start     (st_w[g]),
      .eng_clk_en    (ce_w[g]),
      .eng_theta     (theta),
      .eng_done      (done_r || (force_done && is_sel)),
      .eng_result    (res_r),
      .irq           (irq_w[g])
    );

    // Engine model: done arrives eng_lat cycles after the start cycle; eng_lat == 0 stalls forever.
    always @(posedge clk) begin
      done_r <= 1'b0;
      if (st_w[g]) begin
        act <= (eng_lat != 0);
        cnt <= eng_lat - 1;
      end else if (act) begin
        if (cnt == 1) begin
          done_r <= 1'b1;
          res_r  <= theta ^ 32'h1;
          act    <= 1'b0;
        end
        cnt <= cnt - 1;
      end
    end
  end

  logic [31:0] rdata;
  logic        s_start, s_ce, s_irq;
  assign rdata   = sel ? rd_w[1]  : rd_w[0];
  assign s_start = sel ? st_w[1]  : st_w[0];
  assign s_ce    = sel ? ce_w[1]  : ce_w[0];
  assign s_irq   = sel ? irq_w[1] : irq_w[0];

  int   start_cnt = 0;
  logic mon_en    = 1'b0;
  int   viol      = 0;

  always @(negedge clk) begin
    if (s_start) start_cnt <= start_cnt + 1;
    if (mon_en && (s_start || s_ce)) viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stat(input logic t, input logic u, input logic o,
                                       input logic b, input int oc, input int ic);
    return {12'b0, t, u, o, b, oc[7:0], ic[7:0]};
  endfunction

  task automatic bus_wr(input logic a, input logic [31:0] d);
    @(negedge clk);
    bus_addr  = a;
    bus_wdata = d;
    bus_write = 1'b1;
    @(posedge clk);
    #1 bus_write = 1'b0;
  endtask

  task automatic bus_rd(input logic a, output logic [31:0] d);
    @(negedge clk);
    bus_addr = a;
    bus_read = 1'b1;
    @(posedge clk);
    #1 bus_read = 1'b0;
    @(negedge clk);
    d = rdata;
  endtask

  task automatic chk_status(input string tag, input logic [31:0] exp);
    logic [31:0] s;
    bus_rd(ADDR_STATUS, s);
    chk(tag, s, exp);
  endtask

  task automatic rd_result(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    bus_rd(ADDR_DATA, d);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, d, e);
    end
  endtask

  task automatic wait_out(input int target, input int budget, input string tag);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      bus_rd(ADDR_STATUS, s);
      n++;
    end while ((s[15:8] != target[7:0]) && (n < budget));
    chk(tag, {24'b0, s[15:8]}, {24'b0, target[7:0]});
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!s_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, s_start}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] thetas [3];
    int c0, c1;
    thetas[0] = 32'h3F80_0000;
    thetas[1] = 32'h4000_0000;
    thetas[2] = 32'h0000_0000;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'b0, s_irq}, 32'h0);
    chk("rst_start", {31'b0, s_start}, 32'h0);
    chk("rst_clk_en", {31'b0, s_ce}, 32'h0);
    chk_status("rst_status", 32'h0);

    // Three jobs through a 30-cycle engine come back in order
    eng_lat = 30;
    for (int i = 0; i < 3; i++) begin
      bus_wr(ADDR_DATA, thetas[i]);
      exp_q.push_back(thetas[i] ^ 32'h1);
    end
    wait_out(3, 200, "t1_out_cnt");
    for (int i = 0; i < 3; i++) rd_result("t1_result");
    chk_status("t1_status_empty", 32'h0);
    chk("t1_irq", {31'b0, s_irq}, 32'h0);

    // Stalled engine: one job in WAIT, DEPTH queued, the extra write dropped
    eng_lat = 0;
    for (int i = 0; i < 6; i++) bus_wr(ADDR_DATA, 32'h100 + 32'(i));
    chk_status("t2_ovf", stat(1'b0, 1'b0, 1'b1, 1'b1, 0, DEPTH));
    chk("t2_irq", {31'b0, s_irq}, 32'h1);
    bus_wr(ADDR_STATUS, 32'h0002_0000);
    chk_status("t2_ovf_clr", stat(1'b0, 1'b0, 1'b0, 1'b1, 0, DEPTH));
    do_reset();
    chk_status("t2_after_rst", 32'h0);

    // Underflow on an empty output FIFO
    bus_rd(ADDR_DATA, d);
    chk("t3_rdata", d, 32'h0);
    chk_status("t3_udf", stat(1'b0, 1'b1, 1'b0, 1'b0, 0, 0));
    chk("t3_irq_set", {31'b0, s_irq}, 32'h1);
    bus_wr(ADDR_STATUS, 32'h0004_0000);
    chk_status("t3_udf_clr", 32'h0);
    chk("t3_irq_clr", {31'b0, s_irq}, 32'h0);

    // Reset 5 cycles into WAIT, late done is ignored
    eng_lat = 0;
    bus_wr(ADDR_DATA, 32'h3F00_0000);
    wait_start("t5_start_seen");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1 mon_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    repeat (5) @(negedge clk);
    chk_status("t5_status", 32'h0);
    chk("t5_irq", {31'b0, s_irq}, 32'h0);
    mon_en = 1'b0;
    chk("t5_no_start_clk_en", 32'(viol), 32'h0);

    // Output FIFO full holds off new jobs until a slot is read
    eng_lat = 3;
    for (int i = 0; i < 4; i++) begin
      bus_wr(ADDR_DATA, 32'h1000 + 32'(i));
      exp_q.push_back((32'h1000 + 32'(i)) ^ 32'h1);
    end
    wait_out(4, 100, "t6_out_full");
    c0 = start_cnt;
    for (int i = 0; i < 2; i++) begin
      bus_wr(ADDR_DATA, 32'h2000 + 32'(i));
      exp_q.push_back((32'h2000 + 32'(i)) ^ 32'h1);
    end
    repeat (10) @(negedge clk);
    chk_status("t6_blocked", stat(1'b0, 1'b0, 1'b0, 1'b0, 4, 2));
    chk("t6_no_start", 32'(start_cnt - c0), 32'h0);
    rd_result("t6_r0");
    c1 = start_cnt;
    @(negedge clk);
    chk("t6_issue_next", {31'b0, s_start}, 32'h1);
    repeat (10) @(negedge clk);
    chk("t6_one_job", 32'(start_cnt - c1), 32'h1);
    for (int i = 0; i < 5; i++) begin
      repeat (8) @(negedge clk);
      rd_result("t6_drain");
    end
    chk("t6_sb_left", 32'(exp_q.size()), 32'h0);
    chk_status("t6_status_end", 32'h0);

    // Short-timeout instance: engine silent, qNaN after TIMEOUT cycles of WAIT
    sel = 1'b1;
    do_reset();
    eng_lat = 0;
    c0 = start_cnt;
    bus_wr(ADDR_DATA, 32'h4049_0FDB);
    exp_q.push_back(QNAN);
    wait_start("t4_start_seen");
    // WAIT spans the 16 cycles after the start cycle; the push lands at the end of the 16th.
    repeat (TMO_SHORT) @(negedge clk);
    chk("t4_not_yet", {31'b0, s_irq}, 32'h0);
    @(negedge clk);
    chk("t4_pushed", {31'b0, s_irq}, 32'h1);
    chk("t4_one_start", 32'(start_cnt - c0), 32'h1);
    chk_status("t4_tmo", stat(1'b1, 1'b0, 1'b0, 1'b0, 1, 0));
    rd_result("t4_qnan");
    bus_wr(ADDR_STATUS, 32'h0008_0000);
    chk_status("t4_tmo_clr", 32'h0);

    // done coincides with the last timer cycle: result kept, no timeout
    eng_lat = TMO_SHORT;
    bus_wr(ADDR_DATA, 32'h3F00_0000);
    exp_q.push_back(32'h3F00_0001);
    repeat (30) @(negedge clk);
    chk_status("t4_done_wins", stat(1'b0, 1'b0, 1'b0, 1'b0, 1, 0));
    rd_result("t4_done_result");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
